ex_result_buffer: RTL and testbench

- Sits directly downstream of the EX-stage adder; captures its 32-bit result and its zero/pos/neg/overflow flags, plus destination register and control bits.
- Presents them to the MEM stage through a valid/ready handshake.
- Holds a 2-entry skid buffer so the EX stage sees a registered ready.
- Maintains the architectural condition-code register and a sticky overflow bit, both updated only when an entry retires.

---
 rtl/ex_result_buffer_if.sv | 65 ++++++
 rtl/ex_result_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_ex_result_buffer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_result_buffer_if.sv
// ex_result_buffer_if: EX -> result buffer -> MEM bundle.
// Carries the EX-side push handshake and payload, the MEM-side pop
// handshake and head payload, and the condition-code / sticky overflow
// status. trap_o exists only when VENUS_OVERFLOW_TRAP_EN is defined.
//   slave  : the buffer itself
//   master : the surrounding pipeline (or a testbench driving it)
interface ex_result_buffer_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    // pipeline control
    logic              flush_i;
    logic              clr_sticky_i;

    // EX side
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] result_i;
    logic              zero_flag_i;
    logic              pos_flag_i;
    logic              neg_flag_i;
    logic              overflow_flag_i;
    logic [RD_W-1:0]   rd_i;
    logic              set_flags_i;

    // MEM side
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] result_o;
    logic [RD_W-1:0]   rd_o;
    logic [3:0]        flags_o;

    // architectural status
    logic [3:0]        cc_o;
    logic              sticky_of_o;
`ifdef VENUS_OVERFLOW_TRAP_EN
    logic              trap_o;
`endif

    modport slave (
        input  flush_i, clr_sticky_i,
        input  in_valid_i, result_i, zero_flag_i, pos_flag_i, neg_flag_i,
        input  overflow_flag_i, rd_i, set_flags_i,
        output in_ready_o,
        input  out_ready_i,
        output out_valid_o, result_o, rd_o, flags_o,
`ifdef VENUS_OVERFLOW_TRAP_EN
        output trap_o,
`endif
        output cc_o, sticky_of_o
    );

    modport master (
        output flush_i, clr_sticky_i,
        output in_valid_i, result_i, zero_flag_i, pos_flag_i, neg_flag_i,
        output overflow_flag_i, rd_i, set_flags_i,
        input  in_ready_o,
        output out_ready_i,
        input  out_valid_o, result_o, rd_o, flags_o,
`ifdef VENUS_OVERFLOW_TRAP_EN
        input  trap_o,
`endif
        input  cc_o, sticky_of_o
    );
endinterface

// File: rtl/ex_result_buffer.sv
// ex_result_buffer: two-entry skid buffer between the EX adder and MEM.
//
// The head (main) entry drives the MEM-side outputs directly from flops;
// the skid entry absorbs one extra push so in_ready_o can be a flop output.
// Entries leave strictly in arrival order. The condition-code register and
// sticky overflow bit change only when the head retires with set_flags.
//
// Optional build macro VENUS_OVERFLOW_TRAP_EN: adds trap_o, a one-cycle
// pulse following the retire of a set_flags entry with overflow. That
// retire also empties the buffer (skid and any same-cycle push dropped).
module ex_result_buffer #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ex_result_buffer_if.slave bus
);

    // Flag vector layout is {zero, pos, neg, overflow}.
    localparam int FLAG_OV = 0;
    localparam logic [3:0] CC_RESET = 4'b0100;

    // Encoding chosen so bit 0 is the main-valid flop and bit 1 the
    // skid-valid flop; both handshake outputs are then plain flop bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } occ_t;

    occ_t              state_reg;
    occ_t              state_next;

    // head entry (reset to zero so head outputs are defined after reset)
    logic [DATA_W-1:0] main_result_reg;
    logic [RD_W-1:0]   main_rd_reg;
    logic [3:0]        main_flags_reg;
    logic              main_set_reg;

    // skid entry (contents are don't-care while invalid)
    logic [DATA_W-1:0] skid_result_reg;
    logic [RD_W-1:0]   skid_rd_reg;
    logic [3:0]        skid_flags_reg;
    logic              skid_set_reg;

    // architectural status
    logic [3:0]        cc_reg;
    logic              sticky_reg;

    logic              main_valid;
    logic              skid_valid;
    logic              acc;
    logic              ret;
    logic              ret_sets_cc;
    logic              ret_overflow;
    logic              drop_all;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid_in;
    logic [3:0]        in_flags;

    assign main_valid = state_reg[0];
    assign skid_valid = state_reg[1];

    assign in_flags = {bus.zero_flag_i, bus.pos_flag_i,
                       bus.neg_flag_i, bus.overflow_flag_i};

    assign acc          = bus.in_valid_i & ~skid_valid;
    assign ret          = main_valid & bus.out_ready_i;
    assign ret_sets_cc  = ret & main_set_reg;
    assign ret_overflow = ret_sets_cc & main_flags_reg[FLAG_OV];

`ifdef VENUS_OVERFLOW_TRAP_EN
    logic trap_reg;

    // An overflowing flag-setting retire empties the buffer like a flush.
    assign drop_all   = bus.flush_i | ret_overflow;
    assign bus.trap_o = trap_reg;

    // trap pulse: high for exactly the cycle after the overflow retire
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trap_reg <= 1'b0;
        end else begin
            trap_reg <= ret_overflow;
        end
    end
`else
    assign drop_all = bus.flush_i;
`endif

    // occupancy next-state and slot load selects
    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (drop_all) begin
            // Same-cycle pushes are discarded; a same-cycle retire still
            // counts and is handled by the status logic below.
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (acc) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && ret) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        state_next   = TWO;
                        load_skid_in = 1'b1;
                    end else if (ret) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready_o is low here, so only a retire can happen
                    if (ret) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // occupancy state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // head entry: loads from EX or from the skid, otherwise holds
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_result_reg <= '0;
            main_rd_reg     <= '0;
            main_flags_reg  <= '0;
            main_set_reg    <= 1'b0;
        end else if (load_main_in) begin
            main_result_reg <= bus.result_i;
            main_rd_reg     <= bus.rd_i;
            main_flags_reg  <= in_flags;
            main_set_reg    <= bus.set_flags_i;
        end else if (load_main_skid) begin
            main_result_reg <= skid_result_reg;
            main_rd_reg     <= skid_rd_reg;
            main_flags_reg  <= skid_flags_reg;
            main_set_reg    <= skid_set_reg;
        end
    end

    // skid entry: captures a push that arrives while the head is stalled
    always_ff @(posedge clk_i) begin
        if (load_skid_in) begin
            skid_result_reg <= bus.result_i;
            skid_rd_reg     <= bus.rd_i;
            skid_flags_reg  <= in_flags;
            skid_set_reg    <= bus.set_flags_i;
        end
    end

    // condition codes follow the head's flags on a flag-setting retire
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cc_reg <= CC_RESET;
        end else if (ret_sets_cc) begin
            cc_reg <= main_flags_reg;
        end
    end

    // sticky overflow: a new overflow retire beats a clear request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_reg <= 1'b0;
        end else if (ret_overflow) begin
            sticky_reg <= 1'b1;
        end else if (bus.clr_sticky_i) begin
            sticky_reg <= 1'b0;
        end
    end

    assign bus.in_ready_o  = ~skid_valid;
    assign bus.out_valid_o = main_valid;
    assign bus.result_o    = main_result_reg;
    assign bus.rd_o        = main_rd_reg;
    assign bus.flags_o     = main_flags_reg;
    assign bus.cc_o        = cc_reg;
    assign bus.sticky_of_o = sticky_reg;

endmodule

// File: tb/tb_ex_result_buffer.sv
// tb_ex_result_buffer: directed bench for ex_result_buffer.
// Expected head entries are queued when pushes are driven and checked in
// order whenever the DUT retires one; status outputs are checked at fixed
// points in the sequence. Honours VENUS_OVERFLOW_TRAP_EN like the DUT.
module tb_ex_result_buffer;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic [3:0]        flags;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    ex_result_buffer_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    ex_result_buffer #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DATA_W-1:0] res, input logic [3:0] fl,
                         input logic [RD_W-1:0] rd, input logic set);
        bus.in_valid_i      = 1'b1;
        bus.result_i        = res;
        bus.zero_flag_i     = fl[3];
        bus.pos_flag_i      = fl[2];
        bus.neg_flag_i      = fl[1];
        bus.overflow_flag_i = fl[0];
        bus.rd_i            = rd;
        bus.set_flags_i     = set;
    endtask

    task automatic expect_out(input logic [DATA_W-1:0] res,
                              input logic [RD_W-1:0] rd, input logic [3:0] fl);
        exp_q.push_back('{result: res, rd: rd, flags: fl});
    endtask

    task automatic idle_in();
        bus.in_valid_i = 1'b0;
    endtask

    // retire monitor: every head handed to MEM must match the queue front
    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            exp_t e;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL retire_unexpected: observed result %0h expected no retire",
                       bus.result_o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("retire: result=%08h rd=%0d flags=%04b", bus.result_o,
                         bus.rd_o, bus.flags_o);
                check("retire_result", 64'(bus.result_o), 64'(e.result));
                check("retire_rd", 64'(bus.rd_o), 64'(e.rd));
                check("retire_flags", 64'(bus.flags_o), 64'(e.flags));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.clr_sticky_i = 1'b0;
        bus.out_ready_i = 1'b0;
        idle_in();
        drive('0, 4'b0000, '0, 1'b0);
        idle_in();
        step();
        step();
        rst = 1'b0;

        // reset state
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("rst_result", 64'(bus.result_o), 64'd0);
        check("rst_rd", 64'(bus.rd_o), 64'd0);
        check("rst_flags", 64'(bus.flags_o), 64'd0);
        check("rst_cc", 64'(bus.cc_o), 64'b0100);
        check("rst_sticky", 64'(bus.sticky_of_o), 64'd0);
`ifdef VENUS_OVERFLOW_TRAP_EN
        check("rst_trap", 64'(bus.trap_o), 64'd0);
`endif

        // 1: single push, 1-cycle latency, retire
        bus.out_ready_i = 1'b1;
        drive(32'h8, 4'b0100, 5'd3, 1'b1);
        expect_out(32'h8, 5'd3, 4'b0100);
        step();
        idle_in();
        check("t1_out_valid", 64'(bus.out_valid_o), 64'd1);
        check("t1_result", 64'(bus.result_o), 64'h8);
        step();
        check("t1_empty", 64'(bus.out_valid_o), 64'd0);
        check("t1_cc", 64'(bus.cc_o), 64'b0100);

        // 2: stalled MEM fills main and skid, third push waits
        bus.out_ready_i = 1'b0;
        drive(32'h1, 4'b0100, 5'd1, 1'b0);
        expect_out(32'h1, 5'd1, 4'b0100);
        step();
        check("t2_ready_one", 64'(bus.in_ready_o), 64'd1);
        drive(32'h2, 4'b0100, 5'd2, 1'b0);
        expect_out(32'h2, 5'd2, 4'b0100);
        step();
        check("t2_ready_two", 64'(bus.in_ready_o), 64'd0);
        drive(32'h3, 4'b0100, 5'd5, 1'b0);
        step();
        check("t2_stall_ready", 64'(bus.in_ready_o), 64'd0);
        check("t2_stall_head", 64'(bus.result_o), 64'h1);
        bus.out_ready_i = 1'b1;
        step();
        check("t2_ready_after_drain", 64'(bus.in_ready_o), 64'd1);
        check("t2_head_b", 64'(bus.result_o), 64'h2);
        expect_out(32'h3, 5'd5, 4'b0100);
        step();
        idle_in();
        check("t2_no_bubble", 64'(bus.out_valid_o), 64'd1);
        check("t2_head_c", 64'(bus.result_o), 64'h3);
        step();
        check("t2_empty", 64'(bus.out_valid_o), 64'd0);
        check("t2_queue_drained", 64'(exp_q.size()), 64'd0);

        // 3: overflow retire sets sticky; clear loses to a same-cycle set
        drive(32'h80000000, 4'b0011, 5'd7, 1'b1);
        expect_out(32'h80000000, 5'd7, 4'b0011);
        step();
        idle_in();
        step();
        check("t3_cc", 64'(bus.cc_o), 64'b0011);
        check("t3_sticky_set", 64'(bus.sticky_of_o), 64'd1);
        drive(32'h7fffffff, 4'b0001, 5'd9, 1'b1);
        expect_out(32'h7fffffff, 5'd9, 4'b0001);
        step();
        idle_in();
        bus.clr_sticky_i = 1'b1;
        step();
        bus.clr_sticky_i = 1'b0;
        check("t3_set_beats_clr", 64'(bus.sticky_of_o), 64'd1);
        check("t3_cc2", 64'(bus.cc_o), 64'b0001);
        bus.clr_sticky_i = 1'b1;
        step();
        bus.clr_sticky_i = 1'b0;
        check("t3_clr", 64'(bus.sticky_of_o), 64'd0);

        // 5: retire without set_flags leaves cc alone
        drive(32'h10, 4'b1000, 5'd10, 1'b0);
        expect_out(32'h10, 5'd10, 4'b1000);
        step();
        idle_in();
        step();
        check("t5_cc_hold", 64'(bus.cc_o), 64'b0001);

        // 4: flush in TWO with a retire: head updates cc, skid dropped
        bus.out_ready_i = 1'b0;
        drive(32'h44, 4'b1000, 5'd4, 1'b1);
        expect_out(32'h44, 5'd4, 4'b1000);
        step();
        drive(32'h55, 4'b0010, 5'd11, 1'b0);
        step();
        idle_in();
        bus.flush_i = 1'b1;
        bus.out_ready_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check("t4_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("t4_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("t4_cc", 64'(bus.cc_o), 64'b1000);
        // flush in EMPTY also discards a same-cycle push
        bus.flush_i = 1'b1;
        drive(32'h99, 4'b0100, 5'd12, 1'b1);
        step();
        bus.flush_i = 1'b0;
        idle_in();
        check("t4_push_dropped", 64'(bus.out_valid_o), 64'd0);
        step();
        check("t4_still_empty", 64'(bus.out_valid_o), 64'd0);

        // 6: overflow retire from TWO (trap build drops the skid)
        bus.out_ready_i = 1'b0;
        drive(32'h66, 4'b0101, 5'd6, 1'b1);
        expect_out(32'h66, 5'd6, 4'b0101);
        step();
        drive(32'h77, 4'b0100, 5'd8, 1'b1);
`ifndef VENUS_OVERFLOW_TRAP_EN
        expect_out(32'h77, 5'd8, 4'b0100);
`endif
        step();
        idle_in();
        check("t6_full", 64'(bus.in_ready_o), 64'd0);
        bus.out_ready_i = 1'b1;
        step();
        check("t6_sticky", 64'(bus.sticky_of_o), 64'd1);
`ifdef VENUS_OVERFLOW_TRAP_EN
        check("t6_trap_pulse", 64'(bus.trap_o), 64'd1);
        check("t6_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("t6_cc", 64'(bus.cc_o), 64'b0101);
        step();
        check("t6_trap_end", 64'(bus.trap_o), 64'd0);
`else
        check("t6_out_valid", 64'(bus.out_valid_o), 64'd1);
        check("t6_head", 64'(bus.result_o), 64'h77);
        step();
        check("t6_empty", 64'(bus.out_valid_o), 64'd0);
        check("t6_cc", 64'(bus.cc_o), 64'b0100);
`endif
        check("t6_queue_drained", 64'(exp_q.size()), 64'd0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
